// File: rtl/sram64x8_ctrl.sv
// Host-side initiator for one 64x8 single-port SRAM macro (registered CEN/GWEN/WEN/A/D).
// Define SRAM64X8_CTRL_CLEAR_EN to zero all 64 words after reset before accepting host traffic.
module sram64x8_ctrl (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic [7:0] req_wmask,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       init_done,
  output logic       sram_cen,
  output logic       sram_gwen,
  output logic [7:0] sram_wen,
  output logic [5:0] sram_a,
  output logic [7:0] sram_d,
  input  logic [7:0] sram_q,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_CLEAR  = 3'd0,
    S_IDLE   = 3'd1,
    S_RD_ACC = 3'd2,
    S_RD_CAP = 3'd3,
    S_RSP    = 3'd4
  } state_t;

`ifdef SRAM64X8_CTRL_CLEAR_EN
  localparam state_t RST_STATE = S_CLEAR;
`else
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t     r_state, w_state_nxt;
  logic       r_cen, w_cen;
  logic       r_gwen, w_gwen;
  logic [7:0] r_wen, w_wen;
  logic [5:0] r_a, w_a;
  logic [7:0] r_d, w_d;
  logic       r_rsp_valid, w_rsp_valid;
  logic [7:0] r_rdata, w_rdata;
  logic       r_init_done, w_init_done;
  logic       w_req_ready;
  logic       w_accept;
`ifdef SRAM64X8_CTRL_CLEAR_EN
  logic [5:0] r_cnt, w_cnt_nxt;
`endif

  // Handshakes: a transfer happens on an edge where valid and ready are both high;
  // valid never waits on ready, and the holder of valid keeps its payload stable until the transfer.
  assign w_req_ready = (r_state == S_IDLE) & r_init_done;
  assign w_accept    = req_valid & w_req_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cen       = 1'b1;
    w_gwen      = 1'b1;
    w_wen       = 8'hFF;
    w_a         = r_a;
    w_d         = r_d;
    w_rsp_valid = r_rsp_valid;
    w_rdata     = r_rdata;
`ifdef SRAM64X8_CTRL_CLEAR_EN
    w_init_done = r_init_done;
    w_cnt_nxt   = r_cnt;
`else
    w_init_done = 1'b1;
`endif
    case (r_state)
`ifdef SRAM64X8_CTRL_CLEAR_EN
      S_CLEAR: begin
        w_cen     = 1'b0;
        w_gwen    = 1'b0;
        w_wen     = 8'h00;
        w_a       = r_cnt;
        w_d       = 8'h00;
        w_cnt_nxt = r_cnt + 6'd1;
        if (r_cnt == 6'd63) begin
          w_state_nxt = S_IDLE;
          w_init_done = 1'b1;
        end
      end
`endif
      S_IDLE: begin
        if (w_accept) begin
          if (req_we) begin
            // An all-zero mask is consumed without touching the macro.
            if (req_wmask != 8'h00) begin
              w_cen  = 1'b0;
              w_gwen = 1'b0;
              w_wen  = ~req_wmask;
              w_a    = req_addr;
              w_d    = req_wdata;
            end
          end else begin
            w_cen       = 1'b0;
            w_a         = req_addr;
            w_state_nxt = S_RD_ACC;
          end
        end
      end
      S_RD_ACC: w_state_nxt = S_RD_CAP;
      S_RD_CAP: begin
        w_rdata     = sram_q;
        w_rsp_valid = 1'b1;
        w_state_nxt = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= RST_STATE;
      r_cen       <= 1'b1;
      r_gwen      <= 1'b1;
      r_wen       <= 8'hFF;
      r_a         <= 6'd0;
      r_d         <= 8'h00;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 8'h00;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cen       <= w_cen;
      r_gwen      <= w_gwen;
      r_wen       <= w_wen;
      r_a         <= w_a;
      r_d         <= w_d;
      r_rsp_valid <= w_rsp_valid;
      r_rdata     <= w_rdata;
      r_init_done <= w_init_done;
    end
  end

`ifdef SRAM64X8_CTRL_CLEAR_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_cnt <= 6'd0;
    else       r_cnt <= w_cnt_nxt;
  end
`endif

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign init_done = r_init_done;
  assign sram_cen  = r_cen;
  assign sram_gwen = r_gwen;
  assign sram_wen  = r_wen;
  assign sram_a    = r_a;
  assign sram_d    = r_d;
  assign dbg_state = r_state;

endmodule
